pkt_hdr_parser: RTL and testbench

- Ingress parse stage in box_250mhz. It sits directly upstream of the p2p match/steer logic that consumes the packet_pkg header types.
- Accepts a 512-bit AXI4-Stream. On the first beat of each packet it extracts the Ethernet, IPv4/IPv6 and TCP/UDP fields.
- Forwards every beat unchanged, 1-cycle registered, with a per-packet metadata sideband held stable for the whole packet.
- Keeps 32-bit wrapping statistics counters.

---
 rtl/pkt_hdr_parser_pkg.sv | 67 ++++++
 rtl/pkt_hdr_parser_skid_buf.sv | 61 ++++++
 rtl/pkt_hdr_parser.sv | 169 ++++++++++++++++
 tb/tb_pkt_hdr_parser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_hdr_parser_pkg.sv
// rtl/pkt_hdr_parser_pkg.sv - header field offsets, length limits and metadata types
package pkt_hdr_parser_pkg;

  // Byte offsets within the first beat of a packet
  localparam int OFF_ETH_TYPE = 12;
  localparam int OFF_IP_VER   = 14;
  localparam int OFF_V4_PROTO = 23;
  localparam int OFF_V4_SRC   = 26;
  localparam int OFF_V4_DST   = 30;
  localparam int OFF_V4_SPORT = 34;
  localparam int OFF_V4_DPORT = 36;
  localparam int OFF_V6_NXT   = 20;
  localparam int OFF_V6_SRC   = 22;
  localparam int OFF_V6_DST   = 38;
  localparam int OFF_V6_SPORT = 54;
  localparam int OFF_V6_DPORT = 56;

  // Minimum byte counts for a packet not to be flagged short
  localparam int MIN_LEN_ETH  = 14;
  localparam int MIN_LEN_IPV4 = 38;
  localparam int MIN_LEN_IPV6 = 58;

  // Byte counts needed before the version nibble / addresses can be trusted
  localparam int MIN_LEN_VER       = OFF_IP_VER + 1;
  localparam int MIN_LEN_IPV4_ADDR = OFF_V4_SPORT;
  localparam int MIN_LEN_IPV6_ADDR = OFF_V6_SPORT;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
  localparam logic [7:0]  PROTO_TCP     = 8'h06;
  localparam logic [7:0]  PROTO_UDP     = 8'h11;

  // Bit positions inside pkt_meta_t.flags
  localparam int META_IPV4      = 0;
  localparam int META_IPV6      = 1;
  localparam int META_TCP       = 2;
  localparam int META_UDP       = 3;
  localparam int META_L4_VALID  = 4;
  localparam int META_SHORT     = 5;
  localparam int META_IPV4_OPTS = 6;

  typedef struct packed {
    logic [7:0]   flags;
    logic [15:0]  eth_type;
    logic [7:0]   proto;
    logic [127:0] src_ip;
    logic [127:0] dst_ip;
    logic [15:0]  src_port;
    logic [15:0]  dst_port;
  } pkt_meta_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  // Number of valid bytes in a beat
  function automatic int byte_count(input logic [63:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/pkt_hdr_parser_skid_buf.sv
// rtl/pkt_hdr_parser_skid_buf.sv - 2-entry registered skid buffer with registered ready
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         skid_valid;
  logic         skid_valid_next;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_free;

  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Skid slot occupancy for the next cycle; ready is derived from it so it can be registered
  always_comb begin
    skid_valid_next = skid_valid;
    if (out_free) begin
      skid_valid_next = 1'b0;
    end else if (in_fire) begin
      skid_valid_next = 1'b1;
    end
  end

  // Output stage refills from the skid slot first, otherwise straight from the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else if (in_fire) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= in_data;
      end
      skid_valid <= skid_valid_next;
      in_ready   <= !skid_valid_next;
    end
  end

endmodule

// File: rtl/pkt_hdr_parser.sv
// rtl/pkt_hdr_parser.sv - first-beat L2/L3/L4 header parser with aligned metadata sideband
module pkt_hdr_parser
  import pkt_hdr_parser_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_rst,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              m_meta_sop,
  output logic [7:0]        m_meta_flags,
  output logic [15:0]       m_meta_eth_type,
  output logic [7:0]        m_meta_proto,
  output logic [127:0]      m_meta_src_ip,
  output logic [127:0]      m_meta_dst_ip,
  output logic [15:0]       m_meta_src_port,
  output logic [15:0]       m_meta_dst_port,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]  stat_ipv4_cnt,
  output logic [CNT_W-1:0]  stat_ipv6_cnt,
  output logic [CNT_W-1:0]  stat_short_cnt
);

  localparam int MSB    = DATA_W - 1;
  localparam int SKID_W = DATA_W + KEEP_W + 1 + $bits(pkt_meta_t) + 1;

  pkt_state_t        state;
  pkt_state_t        state_next;
  logic              sop;
  logic              accept;
  pkt_meta_t         parsed;
  pkt_meta_t         meta_hold;
  pkt_meta_t         in_meta;
  pkt_meta_t         out_meta;
  logic [SKID_W-1:0] in_word;
  logic [SKID_W-1:0] out_word;
  int                len;
  logic [15:0]       eth_type;
  logic [3:0]        ver;
  logic [3:0]        ihl;
  logic              is_v4;
  logic              is_v6;
  logic              v4_opts;
  logic              short_pkt;
  logic              tcp;
  logic              udp;
  logic              l4_valid;

  assign accept = s_axis_tvalid && s_axis_tready;

  // Packet-boundary state register
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Enter the packet on a non-last beat, leave it on the last beat
  always_comb begin
    state_next = state;
    if (accept) state_next = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
  end

  // A beat arriving outside a packet is the first beat
  always_comb begin
    sop = (state == ST_IDLE);
  end

  // Classify the current beat as if it were the first beat; only used when sop is set
  always_comb begin
    len       = s_axis_tlast ? byte_count(s_axis_tkeep) : KEEP_W;
    eth_type  = s_axis_tdata[MSB-8*OFF_ETH_TYPE -: 16];
    ver       = s_axis_tdata[MSB-8*OFF_IP_VER -: 4];
    ihl       = s_axis_tdata[MSB-8*OFF_IP_VER-4 -: 4];
    is_v4     = (eth_type == ETH_TYPE_IPV4) && (ver == 4'd4) && (len >= MIN_LEN_VER);
    is_v6     = (eth_type == ETH_TYPE_IPV6) && (ver == 4'd6) && (len >= MIN_LEN_VER);
    v4_opts   = is_v4 && (ihl != 4'd5);
    short_pkt = (len < MIN_LEN_ETH) || (is_v4 && len < MIN_LEN_IPV4) ||
                (is_v6 && len < MIN_LEN_IPV6);
    parsed          = '0;
    parsed.eth_type = eth_type;
    if (is_v4 && len >= MIN_LEN_IPV4_ADDR) begin
      parsed.proto  = s_axis_tdata[MSB-8*OFF_V4_PROTO -: 8];
      parsed.src_ip = {96'b0, s_axis_tdata[MSB-8*OFF_V4_SRC -: 32]};
      parsed.dst_ip = {96'b0, s_axis_tdata[MSB-8*OFF_V4_DST -: 32]};
    end else if (is_v6 && len >= MIN_LEN_IPV6_ADDR) begin
      parsed.proto  = s_axis_tdata[MSB-8*OFF_V6_NXT -: 8];
      parsed.src_ip = s_axis_tdata[MSB-8*OFF_V6_SRC -: 128];
      parsed.dst_ip = s_axis_tdata[MSB-8*OFF_V6_DST -: 128];
    end
    tcp      = (is_v4 || is_v6) && (parsed.proto == PROTO_TCP);
    udp      = (is_v4 || is_v6) && (parsed.proto == PROTO_UDP);
    l4_valid = (tcp || udp) && !v4_opts && !short_pkt;
    if (l4_valid) begin
      if (is_v4) begin
        parsed.src_port = s_axis_tdata[MSB-8*OFF_V4_SPORT -: 16];
        parsed.dst_port = s_axis_tdata[MSB-8*OFF_V4_DPORT -: 16];
      end else begin
        parsed.src_port = s_axis_tdata[MSB-8*OFF_V6_SPORT -: 16];
        parsed.dst_port = s_axis_tdata[MSB-8*OFF_V6_DPORT -: 16];
      end
    end
    parsed.flags[META_IPV4]      = is_v4;
    parsed.flags[META_IPV6]      = is_v6;
    parsed.flags[META_TCP]       = tcp;
    parsed.flags[META_UDP]       = udp;
    parsed.flags[META_L4_VALID]  = l4_valid;
    parsed.flags[META_SHORT]     = short_pkt;
    parsed.flags[META_IPV4_OPTS] = v4_opts;
    in_meta = sop ? parsed : meta_hold;
  end

  // Remember the first-beat metadata so later beats of the packet carry the same sideband
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst)          meta_hold <= '0;
    else if (accept && sop) meta_hold <= parsed;
  end

  // Per-packet statistics, counted as each first beat is accepted
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      stat_pkt_cnt   <= '0;
      stat_ipv4_cnt  <= '0;
      stat_ipv6_cnt  <= '0;
      stat_short_cnt <= '0;
    end else if (accept && sop) begin
      stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
      if (is_v4)     stat_ipv4_cnt  <= stat_ipv4_cnt + CNT_W'(1);
      if (is_v6)     stat_ipv6_cnt  <= stat_ipv6_cnt + CNT_W'(1);
      if (short_pkt) stat_short_cnt <= stat_short_cnt + CNT_W'(1);
    end
  end

  // Data and metadata travel through one buffer so they can never slip apart
  assign in_word = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, in_meta, sop};

  axis_skid_buf #(
    .W (SKID_W)
  ) u_skid (
    .clk       (axis_aclk),
    .rst       (axis_rst),
    .in_valid  (s_axis_tvalid),
    .in_data   (in_word),
    .in_ready  (s_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (out_word),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, out_meta, m_meta_sop} = out_word;
  assign m_meta_flags    = out_meta.flags;
  assign m_meta_eth_type = out_meta.eth_type;
  assign m_meta_proto    = out_meta.proto;
  assign m_meta_src_ip   = out_meta.src_ip;
  assign m_meta_dst_ip   = out_meta.dst_ip;
  assign m_meta_src_port = out_meta.src_port;
  assign m_meta_dst_port = out_meta.dst_port;

endmodule

// File: tb/tb_pkt_hdr_parser.sv
// tb/tb_pkt_hdr_parser.sv - directed self-checking bench for pkt_hdr_parser
module tb_pkt_hdr_parser;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_axis_tvalid = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic         m_axis_tvalid;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic         m_meta_sop;
  logic [7:0]   m_meta_flags;
  logic [15:0]  m_meta_eth_type;
  logic [7:0]   m_meta_proto;
  logic [127:0] m_meta_src_ip;
  logic [127:0] m_meta_dst_ip;
  logic [15:0]  m_meta_src_port;
  logic [15:0]  m_meta_dst_port;
  logic [31:0]  stat_pkt_cnt;
  logic [31:0]  stat_ipv4_cnt;
  logic [31:0]  stat_ipv6_cnt;
  logic [31:0]  stat_short_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit bp_mode = 1'b0;
  int stall_viol = 0;
  int stall_cycles = 0;
  logic prev_stall = 1'b0;
  logic [538:0] prev_word = '0;

  logic [511:0] obs_data_q[$];
  logic [15:0]  obs_port_q[$];
  logic         obs_sop_q[$];
  logic [511:0] exp_data_q[$];
  logic [15:0]  exp_port_q[$];
  logic         exp_sop_q[$];

  pkt_hdr_parser dut (
    .axis_aclk       (clk),
    .axis_rst        (rst),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .m_meta_sop      (m_meta_sop),
    .m_meta_flags    (m_meta_flags),
    .m_meta_eth_type (m_meta_eth_type),
    .m_meta_proto    (m_meta_proto),
    .m_meta_src_ip   (m_meta_src_ip),
    .m_meta_dst_ip   (m_meta_dst_ip),
    .m_meta_src_port (m_meta_src_port),
    .m_meta_dst_port (m_meta_dst_port),
    .stat_pkt_cnt    (stat_pkt_cnt),
    .stat_ipv4_cnt   (stat_ipv4_cnt),
    .stat_ipv6_cnt   (stat_ipv6_cnt),
    .stat_short_cnt  (stat_short_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] d, input int b, input int n,
                                       input logic [127:0] v);
    logic [511:0] r;
    r = d;
    for (int i = 0; i < n; i++) r[511-8*(b+i) -: 8] = v[8*(n-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [511:0] mk_eth(input logic [15:0] et);
    logic [511:0] d;
    d = {16{32'hC3A55A3C}};
    return put(d, 12, 2, 128'(et));
  endfunction

  function automatic logic [511:0] mk_v4(input logic [3:0] ihl, input logic [7:0] proto,
                                         input logic [31:0] src, input logic [31:0] dst,
                                         input logic [15:0] sp, input logic [15:0] dp);
    logic [511:0] d;
    d = mk_eth(16'h0800);
    d = put(d, 14, 1, 128'({4'h4, ihl}));
    d = put(d, 23, 1, 128'(proto));
    d = put(d, 26, 4, 128'(src));
    d = put(d, 30, 4, 128'(dst));
    d = put(d, 34, 2, 128'(sp));
    d = put(d, 36, 2, 128'(dp));
    return d;
  endfunction

  function automatic logic [511:0] mk_v6(input logic [7:0] nh, input logic [127:0] src,
                                         input logic [127:0] dst, input logic [15:0] sp,
                                         input logic [15:0] dp);
    logic [511:0] d;
    d = mk_eth(16'h86DD);
    d = put(d, 14, 1, 128'(8'h60));
    d = put(d, 20, 1, 128'(nh));
    d = put(d, 22, 16, src);
    d = put(d, 38, 16, dst);
    d = put(d, 54, 2, 128'(sp));
    d = put(d, 56, 2, 128'(dp));
    return d;
  endfunction

  function automatic logic [63:0] keep_n(input int n);
    logic [63:0] k;
    k = '1;
    return (n == 0) ? 64'b0 : (k << (64 - n));
  endfunction

  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
    int n;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    n = 0;
    while (!s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) chk("send_ready_timeout", 512'(s_axis_tready), 512'(1'b1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Downstream model: drives tready, records handshakes, watches stalled outputs
  initial begin
    forever begin
      @(negedge clk);
      m_axis_tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && ({m_axis_tvalid, m_axis_tdata, m_meta_src_port, m_meta_sop,
                            m_meta_flags, m_axis_tlast} !== prev_word))
          stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        if (prev_stall) stall_cycles++;
        prev_word = {m_axis_tvalid, m_axis_tdata, m_meta_src_port, m_meta_sop,
                     m_meta_flags, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready) begin
          obs_data_q.push_back(m_axis_tdata);
          obs_port_q.push_back(m_meta_src_port);
          obs_sop_q.push_back(m_meta_sop);
        end
      end
    end
  end

  initial begin
    logic [511:0] d0;
    logic [511:0] d1;
    logic [511:0] d2;
    int w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 512'(s_axis_tready), 512'(1'b0));
    chk("rst_m_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
    chk("rst_m_tdata", m_axis_tdata, 512'(0));
    chk("rst_flags", 512'(m_meta_flags), 512'(8'h00));
    chk("rst_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", 512'(s_axis_tready), 512'(1'b1));

    // IPv4/UDP single 64 B beat
    d0 = mk_v4(4'h5, 8'h11, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd4789);
    send(d0, '1, 1'b1);
    chk("v4udp_tvalid", 512'(m_axis_tvalid), 512'(1'b1));
    chk("v4udp_tdata", m_axis_tdata, d0);
    chk("v4udp_sop", 512'(m_meta_sop), 512'(1'b1));
    chk("v4udp_flags", 512'(m_meta_flags), 512'(8'h19));
    chk("v4udp_eth", 512'(m_meta_eth_type), 512'(16'h0800));
    chk("v4udp_proto", 512'(m_meta_proto), 512'(8'h11));
    chk("v4udp_src_ip", 512'(m_meta_src_ip), 512'(128'h0A000001));
    chk("v4udp_dst_ip", 512'(m_meta_dst_ip), 512'(128'h0A000002));
    chk("v4udp_sport", 512'(m_meta_src_port), 512'(16'h04D2));
    chk("v4udp_dport", 512'(m_meta_dst_port), 512'(16'h12B5));
    chk("v4udp_ipv4_cnt", 512'(stat_ipv4_cnt), 512'(32'd1));
    @(posedge clk);
    #1;
    chk("v4udp_tvalid_drop", 512'(m_axis_tvalid), 512'(1'b0));

    // IPv6/TCP three beats; metadata held, sop only on the first
    d0 = mk_v6(8'h06, 128'h20010DB8000000000000000000000001,
               128'h20010DB8000000000000000000000002, 16'd80, 16'd443);
    d1 = {16{32'h11112222}};
    d2 = {16{32'h33334444}};
    send(d0, '1, 1'b0);
    chk("v6_b0_sop", 512'(m_meta_sop), 512'(1'b1));
    chk("v6_b0_flags", 512'(m_meta_flags), 512'(8'h16));
    chk("v6_b0_src_ip", 512'(m_meta_src_ip), 512'(128'h20010DB8000000000000000000000001));
    chk("v6_b0_sport", 512'(m_meta_src_port), 512'(16'd80));
    send(d1, '1, 1'b0);
    chk("v6_b1_sop", 512'(m_meta_sop), 512'(1'b0));
    chk("v6_b1_flags", 512'(m_meta_flags), 512'(8'h16));
    chk("v6_b1_dport", 512'(m_meta_dst_port), 512'(16'd443));
    chk("v6_b1_tdata", m_axis_tdata, d1);
    send(d2, keep_n(20), 1'b1);
    chk("v6_b2_sop", 512'(m_meta_sop), 512'(1'b0));
    chk("v6_b2_flags", 512'(m_meta_flags), 512'(8'h16));
    chk("v6_b2_dst_ip", 512'(m_meta_dst_ip), 512'(128'h20010DB8000000000000000000000002));
    chk("v6_b2_tkeep", 512'(m_axis_tkeep), 512'(keep_n(20)));
    chk("v6_b2_tlast", 512'(m_axis_tlast), 512'(1'b1));
    chk("v6_ipv6_cnt", 512'(stat_ipv6_cnt), 512'(32'd1));

    // IPv4 with options: TCP recognised but L4 not trusted
    send(mk_v4(4'h6, 8'h06, 32'hC0A80001, 32'hC0A80002, 16'd1000, 16'd2000), '1, 1'b1);
    chk("v4opt_flags", 512'(m_meta_flags), 512'(8'h45));
    chk("v4opt_sport", 512'(m_meta_src_port), 512'(16'd0));
    chk("v4opt_dport", 512'(m_meta_dst_port), 512'(16'd0));

    // Short IPv4/TCP, 36 bytes: addresses present, ports dropped
    send(mk_v4(4'h5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1111, 16'd2222), keep_n(36), 1'b1);
    chk("short36_flags", 512'(m_meta_flags), 512'(8'h25));
    chk("short36_src_ip", 512'(m_meta_src_ip), 512'(128'h0A000001));
    chk("short36_dport", 512'(m_meta_dst_port), 512'(16'd0));
    chk("short36_short_cnt", 512'(stat_short_cnt), 512'(32'd1));

    // Short IPv4/TCP, 33 bytes: addresses and protocol dropped too
    send(mk_v4(4'h5, 8'h06, 32'h0A000001, 32'h0A000002, 16'd1111, 16'd2222), keep_n(33), 1'b1);
    chk("short33_flags", 512'(m_meta_flags), 512'(8'h21));
    chk("short33_src_ip", 512'(m_meta_src_ip), 512'(0));
    chk("short33_proto", 512'(m_meta_proto), 512'(8'h00));

    // Exactly 38 bytes of IPv4/UDP is not short
    send(mk_v4(4'h5, 8'h11, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd4789), keep_n(38), 1'b1);
    chk("len38_flags", 512'(m_meta_flags), 512'(8'h19));
    chk("len38_dport", 512'(m_meta_dst_port), 512'(16'h12B5));
    chk("len38_short_cnt", 512'(stat_short_cnt), 512'(32'd2));

    // Non-IP frame: only the EtherType is reported
    send(mk_eth(16'h88CC), keep_n(60), 1'b1);
    chk("nonip_flags", 512'(m_meta_flags), 512'(8'h00));
    chk("nonip_eth", 512'(m_meta_eth_type), 512'(16'h88CC));
    chk("nonip_src_ip", 512'(m_meta_src_ip), 512'(0));
    chk("nonip_sport", 512'(m_meta_src_port), 512'(16'd0));
    chk("tot_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd7));
    chk("tot_ipv4_cnt", 512'(stat_ipv4_cnt), 512'(32'd5));

    // Back-pressure: 100 back-to-back packets of 1..3 beats with random downstream ready
    do_reset();
    obs_data_q.delete();
    obs_port_q.delete();
    obs_sop_q.delete();
    bp_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 1 + i % 3; j++) begin
        if (j == 0) d0 = mk_v4(4'h5, 8'h11, 32'h0A000000 + i, 32'h0A0000FF, 16'(i), 16'h12B5);
        else        d0 = {16{16'(i), 8'(j), 8'h5A}};
        exp_data_q.push_back(d0);
        exp_port_q.push_back(16'(i));
        exp_sop_q.push_back(j == 0);
        send(d0, '1, (j == i % 3));
      end
    end
    w = 0;
    while (obs_data_q.size() < exp_data_q.size() && w < 5000) begin
      @(negedge clk);
      w++;
    end
    bp_mode = 1'b0;
    chk("bp_beat_count", 512'(obs_data_q.size()), 512'(exp_data_q.size()));
    for (int k = 0; k < exp_data_q.size() && k < obs_data_q.size(); k++) begin
      chk($sformatf("bp_data[%0d]", k), obs_data_q[k], exp_data_q[k]);
      chk($sformatf("bp_sport[%0d]", k), 512'(obs_port_q[k]), 512'(exp_port_q[k]));
      chk($sformatf("bp_sop[%0d]", k), 512'(obs_sop_q[k]), 512'(exp_sop_q[k]));
    end
    chk("bp_stall_stable", 512'(stall_viol), 512'(0));
    chk("bp_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd100));
    chk("bp_ipv4_cnt", 512'(stat_ipv4_cnt), 512'(32'd100));

    // Reset after beat 2 of a 4-beat packet; the next beat must start a new packet
    send(mk_v4(4'h5, 8'h06, 32'h01020304, 32'h05060708, 16'd7, 16'd8), '1, 1'b0);
    send({16{32'h77778888}}, '1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
    chk("midrst_m_tdata", m_axis_tdata, 512'(0));
    chk("midrst_flags", 512'(m_meta_flags), 512'(8'h00));
    chk("midrst_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd0));
    chk("midrst_ipv4_cnt", 512'(stat_ipv4_cnt), 512'(32'd0));
    chk("midrst_s_tready", 512'(s_axis_tready), 512'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    d0 = mk_v6(8'h11, 128'hFE800000000000000000000000000001,
               128'hFE800000000000000000000000000002, 16'd53, 16'd5353);
    send(d0, '1, 1'b1);
    chk("postrst_sop", 512'(m_meta_sop), 512'(1'b1));
    chk("postrst_flags", 512'(m_meta_flags), 512'(8'h1A));
    chk("postrst_dport", 512'(m_meta_dst_port), 512'(16'h14E9));
    chk("postrst_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd1));
    chk("postrst_ipv6_cnt", 512'(stat_ipv6_cnt), 512'(32'd1));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
